// File: rtl/axis_dac_burst_gen.sv
// Two-channel triggered burst generator: plays preloaded A/B samples from RAM
// with per-channel Q2.14 gain, rounding and saturation onto an AXI-Stream master.
module axis_dac_burst_gen #(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH   = 10
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        wr_en,
  input  logic [MEM_ADDR_WIDTH-1:0]   wr_addr,
  input  logic [AXIS_TDATA_WIDTH-1:0] wr_data,
  input  logic [MEM_ADDR_WIDTH:0]     cfg_len,
  input  logic [15:0]                 cfg_cycles,
  input  logic [15:0]                 cfg_gain_a,
  input  logic [15:0]                 cfg_gain_b,
  input  logic                        trig,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [1:0]                  o_dbg_state
);
  localparam int DW   = DAC_DATA_WIDTH;
  localparam int HALF = AXIS_TDATA_WIDTH / 2;
  localparam int AW   = MEM_ADDR_WIDTH;
  localparam int GW   = 16;
  localparam int FRAC = 14;
  localparam int PW   = DW + GW;
  localparam logic signed [PW:0] SAT_MAX = (PW+1)'((1 << (DW-1)) - 1);
  localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_DRAIN = 2'd2} state_t;

  // Stream handshake: a beat transfers on a rising edge where m_axis_tvalid and
  // m_axis_tready are both high; tvalid/tdata hold until then (abort/reset excepted).
  state_t                 r_state, w_state_next;
  logic [AW:0]            r_len;
  logic [15:0]            r_cycles, r_cyc_cnt;
  logic signed [GW-1:0]   r_gain_a, r_gain_b;
  logic [AW-1:0]          r_addr;
  logic                   r_addr_vld, r_ram_vld, r_prod_vld, r_tvalid, r_done;
  logic [2*DW-1:0]        r_mem [2**AW];
  logic [2*DW-1:0]        r_ram_q;
  logic signed [PW-1:0]   r_prod_a, r_prod_b;
  logic [AXIS_TDATA_WIDTH-1:0] r_tdata;

  logic                   w_adv, w_drained, w_wrap, w_accept, w_issue, w_done_set, w_last;
  logic [AW-1:0]          w_seq_addr, w_issue_addr;
  logic [15:0]            w_seq_cyc, w_issue_cyc;

  function automatic logic [HALF-1:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW:0] s;
    logic signed [PW:0] q;
    logic [DW-1:0]      r;
    s = {p[PW-1], p} + (PW+1)'(1 << (FRAC-1));
    q = s >>> FRAC;
    if (q > SAT_MAX)      r = {1'b0, {(DW-1){1'b1}}};
    else if (q < SAT_MIN) r = {1'b1, {(DW-1){1'b0}}};
    else                  r = q[DW-1:0];
    return {{(HALF-DW){r[DW-1]}}, r};
  endfunction

  assign w_adv      = !r_tvalid || m_axis_tready;
  assign w_drained  = !r_addr_vld && !r_ram_vld && !r_prod_vld && w_adv;
  assign w_wrap     = ({1'b0, r_addr} == r_len - (AW+1)'(1));
  assign w_seq_addr = w_wrap ? '0 : r_addr + AW'(1);
  assign w_seq_cyc  = w_wrap ? r_cyc_cnt + 16'd1 : r_cyc_cnt;

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_issue_addr = w_seq_addr;
    w_issue_cyc  = w_seq_cyc;
    w_last       = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      S_IDLE: if (trig && cfg_len != '0) begin
        w_accept     = 1'b1;
        w_issue      = 1'b1;
        w_issue_addr = '0;
        w_issue_cyc  = '0;
        w_last       = (cfg_cycles == 16'd1) && (cfg_len == (AW+1)'(1));
        w_state_next = w_last ? S_DRAIN : S_PLAY;
      end
      S_PLAY: if (w_adv) begin
        w_issue = 1'b1;
        // The final address of the final cycle is the last one issued.
        w_last  = (r_cycles != 16'd0) && ({1'b0, w_seq_addr} == r_len - (AW+1)'(1)) &&
                  (w_seq_cyc == r_cycles - 16'd1);
        if (w_last) w_state_next = S_DRAIN;
      end
      S_DRAIN: if (w_drained) begin
        w_state_next = S_IDLE;
        w_done_set   = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (abort) begin
      w_state_next = S_IDLE;
      w_accept     = 1'b0;
      w_issue      = 1'b0;
      w_done_set   = 1'b0;
    end
  end

  // Registered read; a same-address write in the same cycle returns the old word.
  always_ff @(posedge aclk) begin
    if (wr_en) r_mem[wr_addr] <= {wr_data[HALF+DW-1:HALF], wr_data[DW-1:0]};
    if (w_adv) r_ram_q <= r_mem[r_addr];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_addr_vld <= 1'b0;
      r_ram_vld  <= 1'b0;
      r_prod_vld <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_cyc_cnt  <= '0;
    end else begin
      r_done <= w_done_set;
      if (w_accept) begin
        r_len    <= cfg_len;
        r_cycles <= cfg_cycles;
        r_gain_a <= cfg_gain_a;
        r_gain_b <= cfg_gain_b;
      end
      if (abort) begin
        r_addr_vld <= 1'b0;
        r_ram_vld  <= 1'b0;
        r_prod_vld <= 1'b0;
        r_tvalid   <= 1'b0;
      end else if (w_adv) begin
        r_addr_vld <= w_issue;
        if (w_issue) begin
          r_addr    <= w_issue_addr;
          r_cyc_cnt <= w_issue_cyc;
        end
        r_ram_vld  <= r_addr_vld;
        r_prod_vld <= r_ram_vld;
        r_prod_a   <= PW'($signed(r_ram_q[DW-1:0])) * PW'(r_gain_a);
        r_prod_b   <= PW'($signed(r_ram_q[2*DW-1:DW])) * PW'(r_gain_b);
        r_tvalid   <= r_prod_vld;
        if (r_prod_vld) r_tdata <= {round_sat(r_prod_b), round_sat(r_prod_a)};
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_axis_dac_burst_gen.sv
// Directed and randomized bench for axis_dac_burst_gen with a sample-level
// reference model feeding an expected-beat queue.
module tb_axis_dac_burst_gen;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [10:0] cfg_len = '0;
  logic [15:0] cfg_cycles = '0, cfg_gain_a = '0, cfg_gain_b = '0;
  logic        trig = 1'b0, abort = 1'b0;
  logic        busy, done, m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tready = 1'b1;
  logic [1:0]  dbg_state;

  int n_checks = 0, n_err = 0, n_beats = 0, n_done = 0, cyc = 0, rdy_mode = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_beat = '0, prev_data = '0;
  logic        prev_stall = 1'b0, prev_kill = 1'b0;
  int mem_a[1024];
  int mem_b[1024];

  always #5 aclk = ~aclk;

  axis_dac_burst_gen dut (
    .aclk(aclk), .areset(areset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_len(cfg_len), .cfg_cycles(cfg_cycles), .cfg_gain_a(cfg_gain_a), .cfg_gain_b(cfg_gain_b),
    .trig(trig), .abort(abort), .busy(busy), .done(done), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .o_dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: real-valued gain, round half up, clamp to 14-bit range.
  function automatic logic [15:0] ref_ch(input int s, input int g);
    int p, q;
    p = s * g + 8192;
    if (p >= 0) q = p / 16384;
    else        q = -((-p + 16383) / 16384);
    if (q > 8191)  q = 8191;
    if (q < -8192) q = -8192;
    return 16'(q);
  endfunction

  task automatic push_expected(input int len, input int cycles, input logic [15:0] ga,
                               input logic [15:0] gb);
    for (int c = 0; c < cycles; c++)
      for (int i = 0; i < len; i++)
        exp_q.push_back({ref_ch(mem_b[i], int'($signed(gb))), ref_ch(mem_a[i], int'($signed(ga)))});
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    cyc++;
    case (rdy_mode)
      1:       m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       m_axis_tready = ($urandom_range(0, 3) != 0);
      default: m_axis_tready = 1'b1;
    endcase
  endtask

  task automatic write_ram(input int addr, input int a, input int b);
    wr_en   = 1'b1;
    wr_addr = 10'(addr);
    wr_data = {2'($urandom_range(0, 3)), 14'(b), 2'($urandom_range(0, 3)), 14'(a)};
    mem_a[addr] = a;
    mem_b[addr] = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic write_random(input int n);
    for (int i = 0; i < n; i++)
      write_ram(i, int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
  endtask

  task automatic set_cfg(input int len, input int cycles, input logic [15:0] ga,
                         input logic [15:0] gb);
    cfg_len    = 11'(len);
    cfg_cycles = 16'(cycles);
    cfg_gain_a = ga;
    cfg_gain_b = gb;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (done) seen = 1'b1;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    step();
    check({tag, "_done_once"}, 32'(done), 32'd0);
  endtask

  // Scoreboard / stream monitor, sampled mid-cycle.
  always @(negedge aclk) begin
    if (!areset && prev_stall && !prev_kill) begin
      check("hold_valid", 32'(m_axis_tvalid), 32'd1);
      check("hold_data", m_axis_tdata, prev_data);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_kill  = abort || areset;
    if (m_axis_tvalid && m_axis_tready && !areset) begin
      n_beats++;
      last_beat = m_axis_tdata;
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL extra_beat: observed %0h expected none", m_axis_tdata);
      end
      if (exp_q.size() > 0) check("beat", m_axis_tdata, exp_q.pop_front());
    end
    if (done) n_done++;
  end

  initial begin
    int vcount, d0;
    logic [15:0] ga, gb;

    areset = 1'b1;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    areset = 1'b0;
    step();

    // Ramp playback, latency and contiguity
    for (int i = 0; i < 8; i++) write_ram(i, i, -i);
    set_cfg(8, 2, 16'h4000, 16'h4000);
    push_expected(8, 2, 16'h4000, 16'h4000);
    n_beats = 0;
    pulse_trig();
    check("t1_busy", 32'(busy), 32'd1);
    step();
    step();
    check("t1_latency", 32'(m_axis_tvalid), 32'd0);
    vcount = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (m_axis_tvalid) vcount++;
    end
    check("t1_contig", 32'(vcount), 32'd16);
    step();
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_tvalid_low", 32'(m_axis_tvalid), 32'd0);
    check("t1_beats", 32'(n_beats), 32'd16);
    check("t1_queue", 32'(exp_q.size()), 32'd0);
    step();
    check("t1_done_once", 32'(done), 32'd0);

    // Saturation and rounding
    write_ram(0, 8191, 0);
    set_cfg(1, 1, 16'h7FFF, 16'h4000);
    push_expected(1, 1, 16'h7FFF, 16'h4000);
    pulse_trig();
    wait_done("t2a", 20);
    check("t2_sat_pos", 32'(last_beat[15:0]), 32'h1FFF);
    write_ram(0, -8192, 5);
    push_expected(1, 1, 16'h7FFF, 16'h4000);
    pulse_trig();
    wait_done("t2b", 20);
    check("t2_sat_neg", 32'(last_beat[15:0]), 32'hE000);
    write_ram(0, 3, -3);
    set_cfg(1, 1, 16'h2000, 16'h4000);
    push_expected(1, 1, 16'h2000, 16'h4000);
    pulse_trig();
    wait_done("t2c", 20);
    check("t2_round", 32'(last_beat[15:0]), 32'h0002);

    // Backpressure pattern
    write_random(4);
    ga = 16'($urandom);
    gb = 16'($urandom);
    set_cfg(4, 3, ga, gb);
    push_expected(4, 3, ga, gb);
    rdy_mode = 1;
    n_beats = 0;
    pulse_trig();
    wait_done("t3", 100);
    check("t3_beats", 32'(n_beats), 32'd12);
    rdy_mode = 0;

    // Continuous mode with abort, then restart
    write_random(5);
    set_cfg(5, 0, 16'h4000, 16'hC000);
    push_expected(5, 8, 16'h4000, 16'hC000);
    d0 = n_done;
    n_beats = 0;
    pulse_trig();
    for (int k = 0; k < 200 && n_beats < 23; k++) step();
    check("t4_reached", 32'(n_beats >= 23), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_tvalid_low", 32'(m_axis_tvalid), 32'd0);
    check("t4_busy_low", 32'(busy), 32'd0);
    repeat (3) step();
    check("t4_no_done", 32'(n_done), 32'(d0));
    check("t4_idle_tvalid", 32'(m_axis_tvalid), 32'd0);
    exp_q.delete();
    set_cfg(5, 1, 16'h4000, 16'hC000);
    push_expected(5, 1, 16'h4000, 16'hC000);
    pulse_trig();
    wait_done("t4_restart", 30);

    // Ignored triggers
    set_cfg(4, 2, 16'h4000, 16'h4000);
    push_expected(4, 2, 16'h4000, 16'h4000);
    pulse_trig();
    step();
    cfg_len = 11'd7;
    cfg_gain_a = 16'h1234;
    pulse_trig();
    wait_done("t5_trig_busy", 50);
    cfg_len = 11'd0;
    pulse_trig();
    check("t5_len0_busy", 32'(busy), 32'd0);
    repeat (4) step();
    check("t5_len0_tvalid", 32'(m_axis_tvalid), 32'd0);
    cfg_len = 11'd4;
    trig = 1'b1;
    abort = 1'b1;
    step();
    trig = 1'b0;
    abort = 1'b0;
    check("t5_abort_trig_busy", 32'(busy), 32'd0);
    repeat (4) step();
    check("t5_abort_trig_tvalid", 32'(m_axis_tvalid), 32'd0);

    // Reset mid-burst, RAM survives
    write_random(8);
    ga = 16'($urandom);
    gb = 16'($urandom);
    set_cfg(8, 4, ga, gb);
    push_expected(8, 4, ga, gb);
    pulse_trig();
    repeat (10) step();
    areset = 1'b1;
    step();
    check("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_tdata", m_axis_tdata, 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    areset = 1'b0;
    exp_q.delete();
    step();
    set_cfg(8, 1, ga, gb);
    push_expected(8, 1, ga, gb);
    pulse_trig();
    wait_done("t6_after", 40);

    // Randomized bursts with random backpressure
    for (int r = 0; r < 4; r++) begin
      int len, cycles;
      len    = int'($urandom_range(1, 12));
      cycles = int'($urandom_range(1, 3));
      ga     = 16'($urandom);
      gb     = 16'($urandom);
      write_random(len);
      set_cfg(len, cycles, ga, gb);
      push_expected(len, cycles, ga, gb);
      rdy_mode = 2;
      pulse_trig();
      wait_done("rand", 400);
      rdy_mode = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
